// File: rtl/osc_pkg.sv
// osc_pkg: capture FSM states and default sample/window sizes shared by the
// oscilloscope capture, memory-management and GUI blocks.
package osc_pkg;
    localparam int OSC_SAMPLE_W = 12;
    localparam int OSC_DEPTH    = 640;
    typedef enum logic [1:0] {ST_FILL, ST_ARMED, ST_POST, ST_READY} cap_state_t;
endpackage

// File: rtl/trigger_detect.sv
// trigger_detect: remembers the previous sample of both channels and flags a
// level crossing of the selected channel while the capture FSM is armed.
module trigger_detect
    import osc_pkg::*;
#(
    parameter int SAMPLE_W = OSC_SAMPLE_W
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                valid_i,
    input  logic                arm_i,
    input  logic [SAMPLE_W-1:0] sample_a_i,
    input  logic [SAMPLE_W-1:0] sample_b_i,
    input  logic [SAMPLE_W-1:0] level_i,
    input  logic                channel_i,
    input  logic                edge_i,
    output logic                hit_o
);
    logic [SAMPLE_W-1:0] prev_a_q, prev_b_q, prev, cur;
    logic                vld_q, vld_d;
    // vld drops whenever not armed, so the first armed sample has no usable prev
    assign vld_d = arm_i && (vld_q || valid_i);
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_a_q <= '0;
            prev_b_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            if (valid_i) begin
                prev_a_q <= sample_a_i;
                prev_b_q <= sample_b_i;
            end
            vld_q <= vld_d;
        end
    end
    always_comb begin
        prev  = channel_i ? prev_b_q : prev_a_q;
        cur   = channel_i ? sample_b_i : sample_a_i;
        hit_o = arm_i && valid_i && vld_q &&
                (edge_i ? (prev >= level_i && cur < level_i)
                        : (prev < level_i && cur >= level_i));
    end
endmodule

// File: rtl/trigger_capture.sv
// trigger_capture: circular pre/post-trigger capture of two ADC channels into a
// DEPTH-sample window. Define TRIGGER_AUTO_EN to add the ARMED auto-trigger timeout.
module trigger_capture
    import osc_pkg::*;
#(
    parameter int SAMPLE_W     = OSC_SAMPLE_W,
    parameter int DEPTH        = OSC_DEPTH,
    parameter int PRE_TRIG     = 320,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                     Main_CLK,
    input  logic                     Reset,
    input  logic                     Sample_Valid,
    input  logic [SAMPLE_W-1:0]      Sample_A,
    input  logic [SAMPLE_W-1:0]      Sample_B,
    input  logic [SAMPLE_W-1:0]      Trigger_Level,
    input  logic                     Trigger_Channel,
    input  logic                     Trigger_Edge,
    input  logic                     Pause,
    input  logic                     Frame_Ack,
    output logic                     Wr_En,
    output logic [$clog2(DEPTH)-1:0] Wr_Address,
    output logic [SAMPLE_W-1:0]      Wr_Data_A,
    output logic [SAMPLE_W-1:0]      Wr_Data_B,
    output logic [$clog2(DEPTH)-1:0] Start_Address,
    output logic                     Frame_Ready,
    output logic                     Triggered
);
    localparam int AW  = $clog2(DEPTH);
    localparam int AW1 = AW + 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  PRE_N  = CW'(PRE_TRIG);
    localparam logic [CW-1:0]  POST_N = CW'(DEPTH - PRE_TRIG);
    localparam logic [AW-1:0]  LAST   = AW'(DEPTH - 1);
    localparam logic [AW1-1:0] BACK   = AW1'(DEPTH - PRE_TRIG);
    localparam logic [AW1-1:0] WRAP   = AW1'(DEPTH);

    if (PRE_TRIG < 1 || PRE_TRIG >= DEPTH || AUTO_TIMEOUT < 1) begin : g_bad_cfg
        $error("trigger_capture: PRE_TRIG must be 1..DEPTH-1 and AUTO_TIMEOUT >= 1");
    end

    cap_state_t          state_q, state_d;
    logic [AW-1:0]       ptr_q, ptr_d, start_q, start_d, wr_addr_q, wr_addr_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] wr_a_q, wr_a_d, wr_b_q, wr_b_d;
    logic                wr_en_q, wr_en_d, trig_q, trig_d;
    logic                arm, hit, auto_fire, fire, write;
    logic [AW1-1:0]      back_sum;

    assign arm   = state_q == ST_ARMED;
    // once the post count is full the FSM spends one cycle moving to READY; no writes then
    assign write = Sample_Valid && state_q != ST_READY && !(state_q == ST_POST && cnt_q == POST_N);
    assign fire  = hit || auto_fire;
    assign back_sum = {1'b0, ptr_q} + BACK;

    trigger_detect #(.SAMPLE_W(SAMPLE_W)) u_detect (
        .clk_i      (Main_CLK),
        .rst_i      (Reset),
        .valid_i    (Sample_Valid),
        .arm_i      (arm),
        .sample_a_i (Sample_A),
        .sample_b_i (Sample_B),
        .level_i    (Trigger_Level),
        .channel_i  (Trigger_Channel),
        .edge_i     (Trigger_Edge),
        .hit_o      (hit)
    );

`ifdef TRIGGER_AUTO_EN
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);
    logic [TW-1:0] auto_q, auto_d;
    assign auto_fire = arm && Sample_Valid && !hit && auto_q == TW'(AUTO_TIMEOUT - 1);
    assign auto_d    = (!arm || fire) ? '0 : auto_q + TW'(Sample_Valid);
    always_ff @(posedge Main_CLK or posedge Reset) begin
        if (Reset) auto_q <= '0;
        else       auto_q <= auto_d;
    end
`else
    assign auto_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        start_d   = start_q;
        trig_d    = trig_q;
        wr_en_d   = write;
        wr_addr_d = wr_addr_q;
        wr_a_d    = wr_a_q;
        wr_b_d    = wr_b_q;
        if (write) begin
            wr_addr_d = ptr_q;
            wr_a_d    = Sample_A;
            wr_b_d    = Sample_B;
            ptr_d     = ptr_q == LAST ? '0 : ptr_q + 1'b1;
        end
        case (state_q)
            ST_FILL: if (write) begin
                cnt_d   = cnt_q + 1'b1 == PRE_N ? '0 : cnt_q + 1'b1;
                state_d = cnt_q + 1'b1 == PRE_N ? ST_ARMED : ST_FILL;
            end
            ST_ARMED: if (fire) begin
                cnt_d   = CW'(1);
                state_d = ST_POST;
                start_d = back_sum >= WRAP ? AW'(back_sum - WRAP) : back_sum[AW-1:0];
                trig_d  = !auto_fire;
            end
            ST_POST: begin
                state_d = cnt_q == POST_N ? ST_READY : ST_POST;
                cnt_d   = write ? cnt_q + 1'b1 : cnt_q;
            end
            ST_READY: if (Frame_Ack && !Pause) begin
                state_d = ST_FILL;
                cnt_d   = '0;
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge Main_CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            ptr_q     <= '0;
            start_q   <= '0;
            trig_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_a_q    <= '0;
            wr_b_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            start_q   <= start_d;
            trig_q    <= trig_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_a_q    <= wr_a_d;
            wr_b_q    <= wr_b_d;
        end
    end

    assign Wr_En         = wr_en_q;
    assign Wr_Address    = wr_addr_q;
    assign Wr_Data_A     = wr_a_q;
    assign Wr_Data_B     = wr_b_q;
    assign Start_Address = start_q;
    assign Frame_Ready   = state_q == ST_READY;
    assign Triggered     = trig_q;
endmodule

// File: doc/trigger_capture.md
TRIGGER_CAPTURE -- requirements
Module: trigger_capture

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 12: ADC sample width per channel.
REQ-002 SHALL have parameter DEPTH, default 640: capture window length in samples, one per screen column.
REQ-003 SHALL have parameter PRE_TRIG, default 320: samples retained before the trigger point; legal range 1..DEPTH-1.
REQ-004 SHALL have parameter AUTO_TIMEOUT, default 4096: samples in ARMED before an auto-trigger fires (used only with TRIGGER_AUTO_EN).
REQ-005 SHALL have port Main_CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port Sample_Valid, input, 1 bit: one-cycle strobe marking a new sample pair from the ADC controller.
REQ-008 SHALL have ports Sample_A and Sample_B, input, SAMPLE_W bits each: unsigned channel A/B samples.
REQ-009 SHALL have port Trigger_Level, input, SAMPLE_W bits: unsigned trigger threshold.
REQ-010 SHALL have port Trigger_Channel, input, 1 bit: 0 = A, 1 = B.
REQ-011 SHALL have port Trigger_Edge, input, 1 bit: 0 = rising, 1 = falling.
REQ-012 SHALL have port Pause, input, 1 bit: debounced freeze request.
REQ-013 SHALL have port Frame_Ack, input, 1 bit: consumer has finished reading the frame.
REQ-014 SHALL have ports Wr_En (output, 1), Wr_Address (output, clog2(DEPTH)), Wr_Data_A and Wr_Data_B (output, SAMPLE_W each): channel-buffer write port.
REQ-015 SHALL have port Start_Address, output, clog2(DEPTH): buffer address of the oldest sample in the frame.
REQ-016 SHALL have ports Frame_Ready (output, 1: a complete frame is held) and Triggered (output, 1: 1 = real trigger, 0 = auto).

Function
REQ-017 SHALL implement the states FILL, ARMED, POST and READY.
REQ-018 Each Sample_Valid outside READY SHALL cause, one cycle later: Wr_En=1 for exactly one cycle, Wr_Data = that sample, Wr_Address = write pointer; the pointer then increments, wrapping DEPTH-1 -> 0.
REQ-019 FILL SHALL count PRE_TRIG writes, then move to ARMED.
REQ-020 ARMED SHALL keep writing (circular overwrite); rising edge = prev < Level && cur >= Level; falling edge = prev >= Level && cur < Level; prev = the last sample of the selected channel.
REQ-021 The first sample after entering ARMED SHALL NOT be able to trigger (no valid prev yet).
REQ-022 On the trigger sample, the FSM SHALL go to POST; that sample is write #1 of DEPTH-PRE_TRIG post-trigger writes; Start_Address SHALL be latched = (trigger address - PRE_TRIG) mod DEPTH.
REQ-023 After the final POST write, Frame_Ready SHALL assert on the next cycle and the FSM SHALL be in READY.
REQ-024 In READY, Wr_En SHALL stay 0, Sample_Valid SHALL be ignored, and Start_Address and Triggered SHALL be held.
REQ-025 Frame_Ack in READY with Pause=0 SHALL deassert Frame_Ready next cycle and go to FILL with the pre-count cleared.
REQ-026 Frame_Ack in READY with Pause=1 SHALL be ignored; READY is held until an Ack arrives while Pause=0.
REQ-027 Pause SHALL have no effect outside READY.
REQ-028 Frame_Ack outside READY SHALL be ignored.
REQ-029 Changes to Trigger_Level, Trigger_Channel and Trigger_Edge SHALL take effect on the next sample compare.

Reset
REQ-030 Reset SHALL force: state = FILL; pointer, counters, prev, Start_Address = 0; Wr_En = Frame_Ready = Triggered = 0; Wr_Data = 0.
REQ-031 Reset asserted mid-POST or mid-READY SHALL discard the frame, with no Frame_Ready pulse.

Configuration
REQ-032 With macro TRIGGER_AUTO_EN defined, ARMED SHALL count samples; reaching AUTO_TIMEOUT with no edge SHALL force a trigger on that sample with Triggered = 0. A real edge SHALL set Triggered = 1 and clear the count.
REQ-033 Without TRIGGER_AUTO_EN, ARMED SHALL wait indefinitely, Triggered SHALL always be 1 at READY, and no timeout counter SHALL be synthesized.

Structure
REQ-034 Package osc_pkg SHALL hold the state enum and the SAMPLE_W/DEPTH defaults shared with the memory-management and GUI blocks.
REQ-035 Edge detection SHALL live in one sub-module, trigger_detect (prev register plus compare); the FSM, pointer and counters stay in the top.

Verification
REQ-036 Ramp on A, 0..4095 step 8, Level = 2048, rising: Start_Address = (trigger address - 320) mod 640; the sample at the trigger address = 2048; Frame_Ready after 320 post-trigger writes.
REQ-037 Falling edge on B, Trigger_Channel = 1, constant A: trigger on the first B sample < Level; Triggered = 1.
REQ-038 Constant 100 with Level 2048 and TRIGGER_AUTO_EN: auto-trigger at ARMED sample 4096, Triggered = 0; without the macro, no Frame_Ready after 10000 samples.
REQ-039 READY with Pause = 1, Frame_Ack pulsed: Frame_Ready stays 1 and Wr_En stays 0; drop Pause and Ack again -> Frame_Ready = 0 next cycle, state FILL.
REQ-040 Pointer at 639 with a write: next Wr_Address = 0. Reset pulsed in POST: all outputs 0 and FILL restarts.
